// File: rtl/input_buffer_pp.sv
// Ping-pong input buffer for the polyphase channelizer: two RAM banks of runtime block length N,
// streamed out forward or reversed through a credit-controlled skid FIFO. Optional: INBUF_OVERFLOW_CNT_EN.
module input_buffer_pp #(
    parameter int DATA_WIDTH     = 32,
    parameter int FFT_SIZE_WIDTH = 12,
    parameter int RAM_LAT        = 3
) (
    input  logic                        clk,
    input  logic                        sync_reset,
    input  logic [FFT_SIZE_WIDTH-1:0]   num_phases,
    input  logic                        rev_order,
    input  logic                        s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    output logic                        s_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_final_cnt,
    output logic [FFT_SIZE_WIDTH-2:0]   phase,
    input  logic                        m_axis_tready
`ifdef INBUF_OVERFLOW_CNT_EN
    ,
    output logic [15:0]                 overflow_cnt
`endif
);
    localparam int FW    = FFT_SIZE_WIDTH;
    localparam int AW    = FW - 1;
    localparam int MAXP  = 2 ** AW;
    localparam int DEPTH = RAM_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int UW    = $clog2(2 * DEPTH + 1);

    typedef enum logic {S_IDLE, S_READ} state_t;

    // Block length is carried as N-1 so every index fits the RAM address width.
    function automatic logic [AW-1:0] clamp_nm1(input logic [FW-1:0] n);
        if (n < FW'(2))
            return AW'(1);
        else if (n > FW'(MAXP))
            return AW'(MAXP - 1);
        else
            return AW'(n - FW'(1));
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---------------- write side ----------------
    logic                 r_wr_bank;
    logic [AW-1:0]        r_wr_cnt;
    logic [1:0]           r_full;
    logic [1:0][AW-1:0]   r_bank_nm1;
    logic                 w_wr_acc;
    logic                 w_wr_done;
    logic [AW-1:0]        w_wr_nm1;

    assign s_axis_tready = !r_full[r_wr_bank];
    assign w_wr_acc      = s_axis_tvalid && s_axis_tready;
    assign w_wr_nm1      = (r_wr_cnt == '0) ? clamp_nm1(num_phases) : r_bank_nm1[r_wr_bank];
    assign w_wr_done     = w_wr_acc && (r_wr_cnt == w_wr_nm1);

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_bank_nm1 <= '0;
        end else if (w_wr_acc) begin
            if (r_wr_cnt == '0)
                r_bank_nm1[r_wr_bank] <= w_wr_nm1;
            if (w_wr_done) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= !r_wr_bank;
            end else begin
                r_wr_cnt <= r_wr_cnt + AW'(1);
            end
        end
    end

    // ---------------- read FSM ----------------
    state_t          r_state, w_state_nxt;
    logic [AW-1:0]   r_k, w_k_nxt;
    logic [AW-1:0]   r_rd_nm1, w_nm1_nxt;
    logic            r_rev, w_rev_nxt;
    logic            r_rd_bank, w_rd_bank_nxt;
    logic            w_issue;
    logic            w_rd_release;
    logic            w_last;
    logic            w_credit;
    logic [AW-1:0]   w_raddr;
    logic [UW-1:0]   w_used;
    logic [CW-1:0]   r_fifo_cnt;
    logic [RAM_LAT:1] r_vld_pipe;

    assign w_last   = (r_k == r_rd_nm1);
    assign w_raddr  = r_rev ? (r_rd_nm1 - r_k) : r_k;
    // Entries held plus reads still in the RAM pipe must never exceed FIFO depth.
    assign w_used   = UW'(r_fifo_cnt) + UW'($countones(r_vld_pipe));
    assign w_credit = (w_used < UW'(DEPTH));

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_nm1_nxt     = r_rd_nm1;
        w_rev_nxt     = r_rev;
        w_rd_bank_nxt = r_rd_bank;
        w_issue       = 1'b0;
        w_rd_release  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = S_READ;
                    w_k_nxt     = '0;
                    w_nm1_nxt   = r_bank_nm1[r_rd_bank];
                    w_rev_nxt   = rev_order;
                end
            end
            S_READ: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    w_k_nxt = r_k + AW'(1);
                    if (w_last) begin
                        w_rd_release  = 1'b1;
                        w_rd_bank_nxt = !r_rd_bank;
                        if (r_full[!r_rd_bank]) begin
                            w_k_nxt   = '0;
                            w_nm1_nxt = r_bank_nm1[!r_rd_bank];
                            w_rev_nxt = rev_order;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_rd_nm1  <= '0;
            r_rev     <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_rd_nm1  <= w_nm1_nxt;
            r_rev     <= w_rev_nxt;
            r_rd_bank <= w_rd_bank_nxt;
        end
    end

    // Write-complete and read-release always hit different banks, so both apply.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_done && (r_wr_bank == 1'(b)))
                    r_full[b] <= 1'b1;
                else if (w_rd_release && (r_rd_bank == 1'(b)))
                    r_full[b] <= 1'b0;
            end
        end
    end

    // ---------------- RAM and read pipeline ----------------
    logic [DATA_WIDTH-1:0]              r_mem [2*MAXP];
    logic [RAM_LAT:1][DATA_WIDTH-1:0]   r_dpipe;
    logic [RAM_LAT:1][AW-1:0]           r_ppipe;
    logic [RAM_LAT:1]                   r_fpipe;

    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[{r_wr_bank, r_wr_cnt}] <= s_axis_tdata;
        r_dpipe[1] <= r_mem[{r_rd_bank, w_raddr}];
        r_ppipe[1] <= w_raddr;
        r_fpipe[1] <= w_last;
        for (int i = 2; i <= RAM_LAT; i++) begin
            r_dpipe[i] <= r_dpipe[i-1];
            r_ppipe[i] <= r_ppipe[i-1];
            r_fpipe[i] <= r_fpipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_issue;
            for (int i = 2; i <= RAM_LAT; i++)
                r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    // ---------------- skid FIFO ----------------
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_fifo_d;
    logic [DEPTH-1:0][AW-1:0]         r_fifo_p;
    logic [DEPTH-1:0]                 r_fifo_f;
    logic [PW-1:0]                    r_wp, r_rp;
    logic                             w_push, w_pop;

    assign w_push           = r_vld_pipe[RAM_LAT];
    assign w_pop            = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid    = (r_fifo_cnt != '0);
    assign m_axis_tdata     = r_fifo_d[r_rp];
    assign phase            = r_fifo_p[r_rp];
    assign m_axis_final_cnt = r_fifo_f[r_rp];

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_fifo_d   <= '0;
            r_fifo_p   <= '0;
            r_fifo_f   <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo_d[r_wp] <= r_dpipe[RAM_LAT];
                r_fifo_p[r_wp] <= r_ppipe[RAM_LAT];
                r_fifo_f[r_wp] <= r_fpipe[RAM_LAT];
                r_wp           <= ptr_inc(r_wp);
            end
            if (w_pop)
                r_rp <= ptr_inc(r_rp);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

`ifdef INBUF_OVERFLOW_CNT_EN
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset)
            overflow_cnt <= '0;
        else if (s_axis_tvalid && !s_axis_tready && (overflow_cnt != 16'hFFFF))
            overflow_cnt <= overflow_cnt + 16'd1;
    end
`endif

endmodule
